mcyc_bus_checker: RTL
=====================

Name: mcyc_bus_checker

Overview:
- Parameterised M-cycle/T-cycle bus-sequence checker for the SM83 core; sits beside the CPU in simulation and formal benches.
- Generalises per-instruction address, PC and register-stability checks to any instruction of up to MAX_MCYC M-cycles, with a selectable check mode per M-cycle.
- Tracks the M/T position itself from a start pulse and reports sticky error flags plus the first failing M-cycle.

Parameters:
- MAX_MCYC, 6, max M-cycles checked per run, including the trailing next-opcode fetch; range 2..7.
- ADR_W, 16, address/PC width.
- WATCH_W, 64, width of the register bundle checked for stability.

Ports:
- clk  in  1  system clock; one edge per T-cycle.
- reset  in  1  synchronous, active-high.
- start  in  1  high in the cycle that is M1T1 of the instruction under test.
- n_mcyc  in  3  M-cycles to check including trailing fetch; sampled on start.
- adr  in  ADR_W  CPU bus address.
- rd  in  1  CPU read strobe.
- reg_pc  in  ADR_W  CPU program counter.
- exp_mode  in  2*MAX_MCYC  per-M-cycle mode, slot k-1 = Mk: 0 none, 1 fixed, 2 pc_inc, 3 pc_hold.
- exp_adr  in  ADR_W*MAX_MCYC  per-M-cycle expected address for mode 1.
- watch  in  WATCH_W  registers that must stay stable (BC, DE, HL, F, SP, ...).
- watch_mask  in  WATCH_W  1 = bit is checked.
- busy  out  1  run in progress.
- mcyc  out  3  current M-cycle, 1-based; 0 when idle.
- tcyc  out  2  current T-cycle, 0..3 = T1..T4.
- adr_err  out  1  sticky address mismatch.
- pc_err  out  1  sticky PC-behaviour violation.
- stable_err  out  1  sticky watch-bundle change.
- err_mcyc  out  3  M-cycle of the first error; 0 = none.
- done  out  1  one-cycle pulse after the last checked T4.

Behaviour:
- Reset: state IDLE; busy=0, mcyc=0, tcyc=0, all error flags 0, err_mcyc=0, done=0.
- Position clamping: n_mcyc=0 is treated as 1; n_mcyc>MAX_MCYC is clamped to MAX_MCYC.
- States: IDLE -> RUN on start. RUN -> DONE after MnT4, where n is the clamped n_mcyc. DONE lasts 1 cycle with done=1, then IDLE.
- Counting: the start cycle is M1T1. Outputs are registered, so the cycle after start shows mcyc=1, tcyc=1. tcyc wraps 3->0 and mcyc increments at that wrap.
- Start during RUN or DONE: aborts the current run, clears errors and err_mcyc, restarts at M1T1. Start takes priority over a same-cycle DONE.
- PC capture: pc_t1 = reg_pc at T1 of every M-cycle.
- Mode 1 (fixed): at T3, rd must be 1 and adr must equal exp_adr slot; otherwise adr_err.
- Mode 2 (pc_inc): at T3, rd must be 1 and adr must equal pc_t1, else adr_err. At T4, reg_pc must equal pc_t1+1 mod 2^ADR_W, else pc_err.
- Mode 3 (pc_hold): same T3 address check as mode 2. reg_pc must equal pc_t1 at T2, T3 and T4, else pc_err.
- Mode 0: no address or PC checks for that M-cycle.
- Stability: snapshot = watch at M1T4. From M2T1 through the last T4 inclusive, any bit where (watch ^ snapshot) & watch_mask is set raises stable_err. No stability check when n=1.
- Error latching: all errors are sticky until reset or start. err_mcyc latches mcyc of the first error only. Simultaneous errors set every matching flag; err_mcyc is still the current M-cycle.
- Post-run: error outputs hold their values in IDLE after done, until the next start.
- Size: roughly 200 lines of RTL (position counters, slot muxes, comparators, sticky error logic).

Test Plan:
- LDX A,(nn) pattern: n=5, modes {2,2,2,1,3}, exp_adr[M4]=0xC123. Correct CPU -> done at cycle 20, all error flags 0.
- Same setup, adr=0xC124 at M4T3 -> adr_err=1, err_mcyc=4, pc_err=0.
- Mode 2 at M2 with reg_pc held at 0x0101 -> pc_err=1, err_mcyc=2.
- watch_mask=0xFFFF, bit 3 of watch toggled at M3T2 -> stable_err=1, err_mcyc=3. Same toggle at M1T2 -> no error (before snapshot).
- start re-pulsed at M3T2 after an M2 error -> errors cleared, mcyc=1 next cycle, clean run ends with done.
- n_mcyc=7 with MAX_MCYC=6 -> done after M6T4 (cycle 24). Reset at M2T3 -> busy=0 and all error flags 0 next cycle.

Source files
------------

// File: rtl/mcyc_bus_checker.sv
// M-cycle/T-cycle bus-sequence checker for the SM83 core: follows the M/T position
// from a start pulse, checks address/PC behaviour per M-cycle and register stability.
//
// state  | meaning
// IDLE   | waiting for start; error outputs hold the last run's result
// RUN    | counting M/T position and checking the bus every T-cycle
// DONE   | one cycle after the last checked T4, done=1
module mcyc_bus_checker #(
    parameter int MAX_MCYC = 6,
    parameter int ADR_W    = 16,
    parameter int WATCH_W  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [2:0]                n_mcyc,
    input  logic [ADR_W-1:0]          adr,
    input  logic                      rd,
    input  logic [ADR_W-1:0]          reg_pc,
    input  logic [2*MAX_MCYC-1:0]     exp_mode,
    input  logic [ADR_W*MAX_MCYC-1:0] exp_adr,
    input  logic [WATCH_W-1:0]        watch,
    input  logic [WATCH_W-1:0]        watch_mask,
    output logic                      busy,
    output logic [2:0]                mcyc,
    output logic [1:0]                tcyc,
    output logic                      adr_err,
    output logic                      pc_err,
    output logic                      stable_err,
    output logic [2:0]                err_mcyc,
    output logic                      done
);

    localparam logic [1:0] MODE_NONE    = 2'd0;
    localparam logic [1:0] MODE_FIXED   = 2'd1;
    localparam logic [1:0] MODE_PC_INC  = 2'd2;
    localparam logic [1:0] MODE_PC_HOLD = 2'd3;
    localparam logic [2:0] MAX_M        = 3'(MAX_MCYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         n_clamp;
    logic [2:0]         n_reg;
    logic [2:0]         pos_m;
    logic [1:0]         pos_t;
    logic               last_t4;
    logic [ADR_W-1:0]   pc_t1;
    logic [ADR_W-1:0]   pc_t1_inc;
    logic [WATCH_W-1:0] snap;
    logic [1:0]         cur_mode;
    logic [ADR_W-1:0]   cur_exp;
    logic [ADR_W-1:0]   want_adr;
    logic               chk_en;
    logic               adr_bad;
    logic               pc_bad;
    logic               stab_bad;

    assign n_clamp = (n_mcyc == 3'd0)  ? 3'd1  :
                     (n_mcyc > MAX_M)  ? MAX_M : n_mcyc;

    assign last_t4   = (state == S_RUN) && (pos_m == n_reg) && (pos_t == 2'd3);
    assign chk_en    = (state == S_RUN) && !start;
    assign pc_t1_inc = pc_t1 + ADR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_RUN:   if (last_t4) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
        mcyc = pos_m;
        tcyc = pos_t;
    end

    // The start cycle itself is M1T1, so the registered position begins at M1T2.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_m <= 3'd0;
            pos_t <= 2'd0;
            n_reg <= 3'd1;
        end else if (start) begin
            pos_m <= 3'd1;
            pos_t <= 2'd1;
            n_reg <= n_clamp;
        end else if (state == S_RUN && !last_t4) begin
            pos_t <= pos_t + 2'd1;
            if (pos_t == 2'd3) begin
                pos_m <= pos_m + 3'd1;
            end
        end else begin
            pos_m <= 3'd0;
            pos_t <= 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_t1 <= '0;
            snap  <= '0;
        end else begin
            if (start || (state == S_RUN && pos_t == 2'd0)) begin
                pc_t1 <= reg_pc;
            end
            if (state == S_RUN && pos_m == 3'd1 && pos_t == 2'd3) begin
                snap <= watch;
            end
        end
    end

    always_comb begin
        cur_mode = MODE_NONE;
        cur_exp  = '0;
        for (int k = 0; k < MAX_MCYC; k++) begin
            if (pos_m == 3'(k + 1)) begin
                cur_mode = exp_mode[2*k +: 2];
                cur_exp  = exp_adr[ADR_W*k +: ADR_W];
            end
        end
    end

    always_comb begin
        want_adr = (cur_mode == MODE_FIXED) ? cur_exp : pc_t1;
        adr_bad  = chk_en && (pos_t == 2'd2) && (cur_mode != MODE_NONE) &&
                   (!rd || adr != want_adr);
        pc_bad   = 1'b0;
        if (chk_en && cur_mode == MODE_PC_INC && pos_t == 2'd3) begin
            pc_bad = (reg_pc != pc_t1_inc);
        end
        if (chk_en && cur_mode == MODE_PC_HOLD && pos_t != 2'd0) begin
            pc_bad = (reg_pc != pc_t1);
        end
        // pos_m only reaches 2 when the run has at least two M-cycles.
        stab_bad = chk_en && (pos_m >= 3'd2) && (|((watch ^ snap) & watch_mask));
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            adr_err    <= 1'b0;
            pc_err     <= 1'b0;
            stable_err <= 1'b0;
            err_mcyc   <= 3'd0;
        end else if (chk_en) begin
            adr_err    <= adr_err | adr_bad;
            pc_err     <= pc_err | pc_bad;
            stable_err <= stable_err | stab_bad;
            if ((adr_bad || pc_bad || stab_bad) && err_mcyc == 3'd0) begin
                err_mcyc <= pos_m;
            end
        end
    end

endmodule
